count_event_monitor: RTL and testbench



---
 rtl/count_event_monitor.sv | 176 +++++++++++++++++
 tb/tb_count_event_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_event_monitor
// Description : Samples the accumulator count on every enabled cycle and
//               compares it with the previous sample to detect wrap-around,
//               upward threshold crossings and stalls. Detected events are
//               queued in a small FIFO and drained over valid/ready.
//               Running totals of wraps (modulo 256) and dropped events
//               (saturating) are exposed.
// Ports       : clock, reset     - clock, synchronous active-high reset
//               count_in, en     - sampled count and sample enable
//               threshold        - crossing threshold (sampled when en=1)
//               evt_valid/ready  - event FIFO head handshake
//               evt_type/value   - head event: 01 WRAP, 10 CROSS, 11 STALL
//               wrap_count       - WRAP detections, modulo 256
//               drop_count       - events lost to a full FIFO, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_monitor #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int STALL_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             en,
    input  logic [WIDTH-1:0] threshold,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_type,
    output logic [WIDTH-1:0] evt_value,
    output logic [7:0]       wrap_count,
    output logic [7:0]       drop_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_RUN_W  = $clog2(STALL_LEN + 1);

    localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(STALL_LEN);
    localparam logic [1:0]         c_EVT_NONE = 2'b00;
    localparam logic [1:0]         c_EVT_WRAP = 2'b01;
    localparam logic [1:0]         c_EVT_CROSS = 2'b10;
    localparam logic [1:0]         c_EVT_STALL = 2'b11;

    // ------------------------------------------------------------------
    // Sampling state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_prev;
    logic               r_primed;
    logic [c_RUN_W-1:0] r_stall_run;

    // ------------------------------------------------------------------
    // Event FIFO: pointers carry one extra bit so full and empty differ
    // ------------------------------------------------------------------
    logic [1:0]        r_type_mem  [DEPTH];
    logic [WIDTH-1:0]  r_value_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic [7:0]        r_wrap_count;
    logic [7:0]        r_drop_count;

    logic               w_active;
    logic               w_equal;
    logic               w_wrap;
    logic               w_cross;
    logic               w_stall_fire;
    logic [c_RUN_W-1:0] w_run_next;
    logic [1:0]         w_evt_type;
    logic               w_detect;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // ------------------------------------------------------------------
    // Detection against the previous sample
    // ------------------------------------------------------------------
    always_comb begin
        w_active = en && r_primed;
        w_equal  = (count_in == r_prev);
        w_wrap   = (count_in < r_prev);
        w_cross  = (r_prev < threshold) && (count_in >= threshold);

        // Run length saturates so a held value reports only one stall.
        w_run_next = '0;
        if (w_equal) begin
            w_run_next = (r_stall_run == c_RUN_MAX) ? c_RUN_MAX
                                                    : r_stall_run + c_RUN_W'(1);
        end
        // Fires only on the transition into the saturated count.
        w_stall_fire = w_equal && (r_stall_run != c_RUN_MAX) &&
                       (w_run_next == c_RUN_MAX);

        // Priority: WRAP > CROSS > STALL.
        w_evt_type = c_EVT_NONE;
        if (w_wrap) begin
            w_evt_type = c_EVT_WRAP;
        end else if (w_cross) begin
            w_evt_type = c_EVT_CROSS;
        end else if (w_stall_fire) begin
            w_evt_type = c_EVT_STALL;
        end
        w_detect = w_active && (w_evt_type != c_EVT_NONE);
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                  (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
        w_pop   = !w_empty && evt_ready;
        // A pop in the same cycle frees the slot the push needs.
        w_push  = w_detect && (!w_full || w_pop);
        w_drop  = w_detect && w_full && !w_pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev      <= '0;
            r_primed    <= 1'b0;
            r_stall_run <= '0;
        end else if (en) begin
            r_prev      <= count_in;
            r_primed    <= 1'b1;
            // The priming sample has nothing to compare against.
            r_stall_run <= r_primed ? w_run_next : '0;
        end else begin
            r_primed    <= 1'b0;
            r_stall_run <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_wrap_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_active && w_wrap) begin
                r_wrap_count <= r_wrap_count + 8'd1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    // Storage needs no reset; reads are masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_type_mem[r_wr_ptr[c_ADDR_W-1:0]]  <= w_evt_type;
            r_value_mem[r_wr_ptr[c_ADDR_W-1:0]] <= count_in;
        end
    end

    always_comb begin
        evt_valid  = !w_empty;
        evt_type   = w_empty ? 2'b00 : r_type_mem[r_rd_ptr[c_ADDR_W-1:0]];
        evt_value  = w_empty ? '0 : r_value_mem[r_rd_ptr[c_ADDR_W-1:0]];
        wrap_count = r_wrap_count;
        drop_count = r_drop_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_count_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_event_monitor
// Description : Self-checking bench for count_event_monitor. Directed
//               scenarios plus a randomized run, compared against a
//               queue-based reference model of the event rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_event_monitor;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int STALL_LEN = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] count_in = '0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] threshold = '0;
    logic             evt_valid;
    logic             evt_ready = 1'b0;
    logic [1:0]       evt_type;
    logic [WIDTH-1:0] evt_value;
    logic [7:0]       wrap_count;
    logic [7:0]       drop_count;

    int checks = 0;
    int errors = 0;

    count_event_monitor #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .STALL_LEN(STALL_LEN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .count_in  (count_in),
        .en        (en),
        .threshold (threshold),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_type  (evt_type),
        .evt_value (evt_value),
        .wrap_count(wrap_count),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model: event queue plus the few facts the rules need
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]       t;
        logic [WIDTH-1:0] v;
    } evt_t;

    evt_t       m_q[$];
    int         m_prev   = 0;
    bit         m_primed = 0;
    int         m_equal_run = 0;   // length of the current run of equal samples
    int         m_wrap   = 0;
    int         m_drop   = 0;

    task automatic model_update(input bit r, input bit e, input int c,
                                input int t, input bit rd);
        int   code;
        evt_t ev;
        if (r) begin
            m_q.delete();
            m_prev = 0; m_primed = 0; m_equal_run = 0; m_wrap = 0; m_drop = 0;
            return;
        end
        if (m_q.size() != 0 && rd) void'(m_q.pop_front());
        if (e && m_primed) begin
            code = 0;
            if (c == m_prev) m_equal_run++;
            else m_equal_run = 0;
            if (c < m_prev) code = 1;
            else if (m_prev < t && c >= t) code = 2;
            else if (m_equal_run == STALL_LEN) code = 3;   // exactly once per run
            if (code == 1) m_wrap = (m_wrap + 1) % 256;
            if (code != 0) begin
                ev.t = 2'(code); ev.v = WIDTH'(c);
                if (m_q.size() < DEPTH) m_q.push_back(ev);
                else if (m_drop < 255) m_drop++;
            end
        end else begin
            m_equal_run = 0;
        end
        m_primed = e;
        if (e) m_prev = c;
    endtask

    // Drive one cycle (inputs set 1 time unit after an edge), advance model.
    task automatic step(input bit r, input bit e, input int c, input int t,
                        input bit rd);
        reset = r; en = e; count_in = WIDTH'(c); threshold = WIDTH'(t);
        evt_ready = rd;
        @(posedge clock);
        model_update(r, e, c, t, rd);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if (evt_valid !== 1'b0 || evt_type !== 2'b00 || evt_value !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b type=%b value=%0d, required 0/00/0",
                     evt_valid, evt_type, evt_value);
        end
        checks++;
        if (wrap_count !== 8'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: wrap=%0d drop=%0d, required 0/0",
                     wrap_count, drop_count);
        end
    endtask

    task automatic test_wrap();
        int samp[5]  = '{250, 252, 254, 0, 2};
        bit expv[5]  = '{0, 0, 0, 1, 0};
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, samp[i], 0, 1);
            checks++;
            if (evt_valid !== expv[i]) begin
                errors++;
                $display("FAIL wrap_valid[%0d]: got %b, required %b", i, evt_valid, expv[i]);
            end
            if (expv[i]) begin
                checks++;
                if (evt_type !== 2'b01 || evt_value !== 8'd0) begin
                    errors++;
                    $display("FAIL wrap_event: type=%b value=%0d, required 01/0",
                             evt_type, evt_value);
                end
            end
        end
        checks++;
        if (wrap_count !== 8'd1 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap_totals: wrap=%0d drop=%0d, required 1/0",
                     wrap_count, drop_count);
        end
    endtask

    task automatic test_cross_stall();
        int   samp[11] = '{96, 98, 100, 102, 102, 102, 102, 102, 102, 102, 102};
        logic [1:0] expt[11] = '{0, 0, 2, 0, 0, 0, 0, 3, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            step(0, 1, samp[i], 100, 1);
            checks++;
            if (evt_valid !== (expt[i] != 0)) begin
                errors++;
                $display("FAIL cross_stall_valid[%0d]: got %b, required %b",
                         i, evt_valid, expt[i] != 0);
            end else if (expt[i] != 0 &&
                         (evt_type !== expt[i] || evt_value !== WIDTH'(samp[i]))) begin
                errors++;
                $display("FAIL cross_stall_event[%0d]: type=%b value=%0d, required %b/%0d",
                         i, evt_type, evt_value, expt[i], samp[i]);
            end
        end
    endtask

    task automatic test_priority();
        step(0, 1, 200, 5, 1);
        step(0, 1, 10, 5, 1);
        checks++;
        if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_value !== 8'd10) begin
            errors++;
            $display("FAIL priority_wrap: valid=%b type=%b value=%0d, required 1/01/10",
                     evt_valid, evt_type, evt_value);
        end
        step(0, 0, 10, 5, 1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL priority_single: valid=%b after pop, required 0", evt_valid);
        end
    endtask

    task automatic test_full_drop();
        int samp[7] = '{100, 50, 40, 30, 20, 10, 5};
        int order[4] = '{40, 30, 20, 1};
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, samp[i], 0, 0);
        checks++;
        if (wrap_count !== 8'd6 || drop_count !== 8'd2) begin
            errors++;
            $display("FAIL full_totals: wrap=%0d drop=%0d, required 6/2",
                     wrap_count, drop_count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_type !== 2'b01 || evt_value !== 8'd50) begin
                errors++;
                $display("FAIL head_stable[%0d]: valid=%b type=%b value=%0d, required 1/01/50",
                         i, evt_valid, evt_type, evt_value);
            end
            if (i < 2) step(0, 1, 5, 0, 0);
        end
        // Wrap arrives on the same cycle the full FIFO pops.
        step(0, 1, 1, 0, 1);
        checks++;
        if (wrap_count !== 8'd7 || drop_count !== 8'd2) begin
            errors++;
            $display("FAIL push_on_pop: wrap=%0d drop=%0d, required 7/2",
                     wrap_count, drop_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_value !== WIDTH'(order[i])) begin
                errors++;
                $display("FAIL drain_order[%0d]: valid=%b value=%0d, required 1/%0d",
                         i, evt_valid, evt_value, order[i]);
            end
            step(0, 0, 0, 0, 1);
        end
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b, required 0", evt_valid);
        end
    endtask

    task automatic test_pause();
        step(0, 1, 50, 0, 1);
        step(0, 0, 50, 0, 1);
        step(0, 1, 10, 0, 1);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL pause_reprime: valid=%b, required 0", evt_valid);
        end
        step(0, 1, 12, 0, 1);
        checks++;
        if (evt_valid !== 1'b0 || wrap_count !== 8'd7) begin
            errors++;
            $display("FAIL pause_next: valid=%b wrap=%0d, required 0/7",
                     evt_valid, wrap_count);
        end
    endtask

    task automatic test_reset_mid();
        int samp[6] = '{100, 90, 80, 70, 70, 70};
        for (int i = 0; i < 6; i++) step(0, 1, samp[i], 0, 0);
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_prefill: valid=%b, required 1", evt_valid);
        end
        step(1, 1, 70, 0, 0);
        checks++;
        if (evt_valid !== 1'b0 || wrap_count !== 8'd0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b wrap=%0d drop=%0d, required 0/0/0",
                     evt_valid, wrap_count, drop_count);
        end
        step(0, 1, 70, 0, 0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_sample: valid=%b, required 0", evt_valid);
        end
        step(0, 1, 70, 0, 0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_cleared: valid=%b, required 0", evt_valid);
        end
    endtask

    task automatic test_random();
        int c   = 0;
        int thr = 128;
        bit r, e, rd;
        int k;
        step(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) thr = $urandom_range(0, 255);
            k = $urandom_range(0, 9);
            if (k < 4)      c = c;                                  // stall fodder
            else if (k < 8) c = (c + $urandom_range(1, 20)) % 256;  // climb, wraps
            else            c = $urandom_range(0, 255);
            r  = ($urandom_range(0, 299) == 0);
            e  = ($urandom_range(0, 9) != 0);
            rd = ($urandom_range(0, 2) == 0);
            step(r, e, c, thr, rd);
            checks++;
            if (evt_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid @%0d: got %b, required %b",
                         n, evt_valid, m_q.size() != 0);
            end else if (m_q.size() != 0 &&
                         (evt_type !== m_q[0].t || evt_value !== m_q[0].v)) begin
                errors++;
                $display("FAIL rand_head @%0d: type=%b value=%0d, required %b/%0d",
                         n, evt_type, evt_value, m_q[0].t, m_q[0].v);
            end
            checks++;
            if (wrap_count !== 8'(m_wrap) || drop_count !== 8'(m_drop)) begin
                errors++;
                $display("FAIL rand_counters @%0d: wrap=%0d drop=%0d, required %0d/%0d",
                         n, wrap_count, drop_count, m_wrap, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_cross_stall();
        test_priority();
        test_full_drop();
        test_pause();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
